// File: rtl/axi_lite_master_interface.sv
// axi_lite_master_interface: single-outstanding AXI4-Lite master; define AXI_LITE_MASTER_RR_ARB_EN for round-robin write/read arbitration
module axi_lite_master_interface #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int TRANS_W_STRB_W  = 4,
  parameter int TRANS_WR_RESP_W = 2,
  parameter int TRANS_PROT      = 3
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       i_wr_req,
  input  logic [ADDR_WIDTH-1:0]      i_addr_w,
  input  logic [TRANS_PROT-1:0]      i_awprot_w,
  input  logic [DATA_WIDTH-1:0]      i_data_w,
  input  logic [TRANS_W_STRB_W-1:0]  i_wstrb_w,
  input  logic                       i_rd_req,
  input  logic [ADDR_WIDTH-1:0]      i_addr_r,
  input  logic [TRANS_PROT-1:0]      i_arprot_r,
  output logic                       o_ready,
  output logic                       o_wr_done,
  output logic [TRANS_WR_RESP_W-1:0] o_bresp,
  output logic                       o_rd_done,
  output logic [DATA_WIDTH-1:0]      o_rdata,
  output logic [TRANS_WR_RESP_W-1:0] o_rresp,
  output logic [ADDR_WIDTH-1:0]      o_axi_awaddr,
  output logic [TRANS_PROT-1:0]      o_axi_awprot,
  output logic                       o_axi_awvalid,
  input  logic                       i_axi_awready,
  output logic [DATA_WIDTH-1:0]      o_axi_wdata,
  output logic [TRANS_W_STRB_W-1:0]  o_axi_wstrb,
  output logic                       o_axi_wvalid,
  input  logic                       i_axi_wready,
  input  logic [TRANS_WR_RESP_W-1:0] i_axi_bresp,
  input  logic                       i_axi_bvalid,
  output logic                       o_axi_bready,
  output logic [ADDR_WIDTH-1:0]      o_axi_araddr,
  output logic [TRANS_PROT-1:0]      o_axi_arprot,
  output logic                       o_axi_arvalid,
  input  logic                       i_axi_arready,
  input  logic [DATA_WIDTH-1:0]      i_axi_rdata,
  input  logic [TRANS_WR_RESP_W-1:0] i_axi_rresp,
  input  logic                       i_axi_rvalid,
  output logic                       o_axi_rready
);
  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP} state_t;
  state_t state_q, state_d;
  logic [ADDR_WIDTH-1:0]      awaddr_q, awaddr_d, araddr_q, araddr_d;
  logic [TRANS_PROT-1:0]      awprot_q, awprot_d, arprot_q, arprot_d;
  logic [DATA_WIDTH-1:0]      wdata_q, wdata_d, rdata_q, rdata_d;
  logic [TRANS_W_STRB_W-1:0]  wstrb_q, wstrb_d;
  logic [TRANS_WR_RESP_W-1:0] bresp_q, bresp_d, rresp_q, rresp_d;
  logic awvalid_q, awvalid_d, wvalid_q, wvalid_d, arvalid_q, arvalid_d;
  logic wr_done_q, wr_done_d, rd_done_q, rd_done_d;
  logic idle, grant_wr, grant_rd;
  assign idle = state_q == IDLE;
`ifdef AXI_LITE_MASTER_RR_ARB_EN
  logic last_wr_q;
  // remember the kind granted last so the next tie goes to the other kind
  always_ff @(posedge clk_i) last_wr_q <= reset_i ? 1'b0 : (grant_wr | grant_rd) ? grant_wr : last_wr_q;
  assign grant_wr = idle & i_wr_req & (~i_rd_req | ~last_wr_q);
`else
  assign grant_wr = idle & i_wr_req;
`endif
  assign grant_rd = idle & i_rd_req & ~grant_wr;
  // next state: latch commands, retire each valid on its own handshake, capture responses
  always_comb begin
    state_d   = state_q;
    awaddr_d  = awaddr_q;
    awprot_d  = awprot_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    araddr_d  = araddr_q;
    arprot_d  = arprot_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    arvalid_d = arvalid_q;
    bresp_d   = bresp_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    wr_done_d = 1'b0;
    rd_done_d = 1'b0;
    if (grant_wr) begin
      state_d   = WR_REQ;
      awaddr_d  = i_addr_w;
      awprot_d  = i_awprot_w;
      wdata_d   = i_data_w;
      wstrb_d   = i_wstrb_w;
      awvalid_d = 1'b1;
      wvalid_d  = 1'b1;
    end
    if (grant_rd) begin
      state_d   = RD_REQ;
      araddr_d  = i_addr_r;
      arprot_d  = i_arprot_r;
      arvalid_d = 1'b1;
    end
    if (state_q == WR_REQ) begin
      awvalid_d = awvalid_q & ~i_axi_awready;
      wvalid_d  = wvalid_q & ~i_axi_wready;
      state_d   = (awvalid_d | wvalid_d) ? WR_REQ : WR_RESP;
    end
    if (state_q == WR_RESP && i_axi_bvalid) begin
      bresp_d   = i_axi_bresp;
      wr_done_d = 1'b1;
      state_d   = IDLE;
    end
    if (state_q == RD_REQ) begin
      arvalid_d = arvalid_q & ~i_axi_arready;
      state_d   = arvalid_d ? RD_REQ : RD_RESP;
    end
    if (state_q == RD_RESP && i_axi_rvalid) begin
      rdata_d   = i_axi_rdata;
      rresp_d   = i_axi_rresp;
      rd_done_d = 1'b1;
      state_d   = IDLE;
    end
  end
  // state and output registers; reset aborts any transaction and clears captured results
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      awaddr_q  <= '0;
      awprot_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      araddr_q  <= '0;
      arprot_q  <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      arvalid_q <= 1'b0;
      bresp_q   <= '0;
      rdata_q   <= '0;
      rresp_q   <= '0;
      wr_done_q <= 1'b0;
      rd_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      awaddr_q  <= awaddr_d;
      awprot_q  <= awprot_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      araddr_q  <= araddr_d;
      arprot_q  <= arprot_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      arvalid_q <= arvalid_d;
      bresp_q   <= bresp_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      wr_done_q <= wr_done_d;
      rd_done_q <= rd_done_d;
    end
  end
  assign o_ready       = idle;
  assign o_wr_done     = wr_done_q;
  assign o_bresp       = bresp_q;
  assign o_rd_done     = rd_done_q;
  assign o_rdata       = rdata_q;
  assign o_rresp       = rresp_q;
  assign o_axi_awaddr  = awaddr_q;
  assign o_axi_awprot  = awprot_q;
  assign o_axi_awvalid = awvalid_q;
  assign o_axi_wdata   = wdata_q;
  assign o_axi_wstrb   = wstrb_q;
  assign o_axi_wvalid  = wvalid_q;
  assign o_axi_bready  = state_q == WR_RESP;
  assign o_axi_araddr  = araddr_q;
  assign o_axi_arprot  = arprot_q;
  assign o_axi_arvalid = arvalid_q;
  assign o_axi_rready  = state_q == RD_RESP;
endmodule
